// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a synchronous FIFO memory with a registered read port.
// Issues at most one memory access per cycle and alternates push and pop when both are eligible.
module fifo_ctrl #(
  parameter int DATA_SIZE  = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_SIZE-1:0]  push_data,
  output logic                  push_ready,
  input  logic                  pop,
  output logic                  pop_ready,
  output logic [DATA_SIZE-1:0]  pop_data,
  output logic                  pop_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_SIZE-1:0]  mem_wr_data,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_SIZE-1:0]  mem_rd_data
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] count_next;
  logic                last_grant;
  logic                push_elig;
  logic                pop_elig;
  logic                push_grant;
  logic                pop_grant;

  // Requests are ignored while reset is held so no grant can leak out.
  assign push_elig = push & ~full & ~rst;
  assign pop_elig  = pop & ~empty & ~rst;

  // On a conflict last_grant=1 (pop) favours push, last_grant=0 favours pop.
  assign push_grant = push_elig & (~pop_elig | last_grant);
  assign pop_grant  = pop_elig & (~push_elig | ~last_grant);

  assign push_ready  = push_grant;
  assign pop_ready   = pop_grant;
  assign mem_wr      = push_grant;
  assign mem_rd      = pop_grant;
  assign mem_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign mem_rd_addr = rd_ptr[ADDR_WIDTH-1:0];
  assign mem_wr_data = push_data;
  assign pop_data    = mem_rd_data;

  assign count_next = count + {{ADDR_WIDTH{1'b0}}, push_grant}
                            - {{ADDR_WIDTH{1'b0}}, pop_grant};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      pop_valid  <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (push_grant) wr_ptr <= wr_ptr + 1'b1;
      if (pop_grant)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      full      <= (count_next == FULL_CNT);
      empty     <= (count_next == '0);
      pop_valid <= pop_grant;
      if (push_elig & pop_elig) last_grant <= pop_grant;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl: vector tables for fill/drain/conflict/wrap,
// hand sequences for write-then-read and reset while a read is in flight.
module tb_fifo_ctrl;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          push;
  logic [DW-1:0] push_data;
  logic          push_ready;
  logic          pop;
  logic          pop_ready;
  logic [DW-1:0] pop_data;
  logic          pop_valid;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          mem_wr;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_rd;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;

  logic [DW-1:0] mem [2**AW];

  int applied = 0;
  int miscompares = 0;

  typedef struct {
    logic          push;
    logic          pop;
    logic [DW-1:0] data;
    logic          e_push_ready;
    logic          e_pop_ready;
    logic [AW-1:0] e_wr_addr;
    logic [AW-1:0] e_rd_addr;
    logic [AW:0]   e_count;
    logic          e_pop_valid;
    logic [DW-1:0] e_pop_data;
  } vec_t;

  vec_t vq[$];

  fifo_ctrl #(.DATA_SIZE(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .push(push), .push_data(push_data), .push_ready(push_ready),
    .pop(pop), .pop_ready(pop_ready), .pop_data(pop_data), .pop_valid(pop_valid),
    .full(full), .empty(empty), .count(count),
    .mem_wr(mem_wr), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd(mem_rd), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous memory with registered read data.
  always @(posedge clk) begin
    if (mem_wr) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_rd) mem_rd_data <= mem[mem_rd_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic pu, input logic po, input logic [DW-1:0] d,
                     input logic epr, input logic eor, input int wa, input int ra,
                     input int cnt, input logic epv, input logic [DW-1:0] epd);
    vec_t v;
    v.push = pu; v.pop = po; v.data = d;
    v.e_push_ready = epr; v.e_pop_ready = eor;
    v.e_wr_addr = AW'(wa); v.e_rd_addr = AW'(ra);
    v.e_count = (AW+1)'(cnt); v.e_pop_valid = epv; v.e_pop_data = epd;
    vq.push_back(v);
  endtask

  // Entered and left at posedge+1.
  task automatic run_vecs(input string tag);
    foreach (vq[i]) begin
      push = vq[i].push; pop = vq[i].pop; push_data = vq[i].data;
      #3;
      chk({tag, " push_ready"}, push_ready, vq[i].e_push_ready);
      chk({tag, " pop_ready"}, pop_ready, vq[i].e_pop_ready);
      chk({tag, " mem_wr"}, mem_wr, vq[i].e_push_ready);
      chk({tag, " mem_rd"}, mem_rd, vq[i].e_pop_ready);
      if (vq[i].e_push_ready) begin
        chk({tag, " wr_addr"}, mem_wr_addr, vq[i].e_wr_addr);
        chk({tag, " wr_data"}, mem_wr_data, vq[i].data);
      end
      if (vq[i].e_pop_ready) chk({tag, " rd_addr"}, mem_rd_addr, vq[i].e_rd_addr);
      @(posedge clk); #1;
      chk({tag, " count"}, count, vq[i].e_count);
      chk({tag, " full"}, full, vq[i].e_count == 5'd16);
      chk({tag, " empty"}, empty, vq[i].e_count == 5'd0);
      chk({tag, " pop_valid"}, pop_valid, vq[i].e_pop_valid);
      if (vq[i].e_pop_valid) chk({tag, " pop_data"}, pop_data, vq[i].e_pop_data);
    end
    vq.delete();
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic do_reset();
    push = 1'b0; pop = 1'b0; push_data = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst count", count, 0);
    chk("rst empty", empty, 1);
    chk("rst full", full, 0);
    chk("rst pop_valid", pop_valid, 0);
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
    #1;
    do_reset();

    // Fill, overflow attempt, drain, underflow attempt.
    for (int i = 0; i < 16; i++) add(1, 0, DW'(16'h1000 + i), 1, 0, i, 0, i + 1, 0, 0);
    add(1, 0, 16'hDEAD, 0, 0, 0, 0, 16, 0, 0);
    for (int i = 0; i < 16; i++) add(0, 1, 0, 0, 1, 0, i, 15 - i, 1, DW'(16'h1000 + i));
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_vecs("fill_drain");

    // Conflicts alternate starting with push.
    do_reset();
    for (int i = 0; i < 5; i++) add(1, 0, DW'(16'h2000 + i), 1, 0, i, 0, i + 1, 0, 0);
    add(1, 1, 16'h2005, 1, 0, 5, 0, 6, 0, 0);
    add(1, 1, 16'h2006, 0, 1, 0, 0, 5, 1, 16'h2000);
    add(1, 1, 16'h2006, 1, 0, 6, 0, 6, 0, 0);
    add(1, 1, 16'h2007, 0, 1, 0, 1, 5, 1, 16'h2001);
    add(1, 1, 16'h2007, 1, 0, 7, 0, 6, 0, 0);
    run_vecs("conflict");

    // Address wrap-around.
    do_reset();
    for (int i = 0; i < 12; i++) add(1, 0, DW'(16'h3000 + i), 1, 0, i, 0, i + 1, 0, 0);
    for (int i = 0; i < 12; i++) add(0, 1, 0, 0, 1, 0, i, 11 - i, 1, DW'(16'h3000 + i));
    for (int i = 0; i < 8; i++) add(1, 0, DW'(16'h3100 + i), 1, 0, (12 + i) % 16, 0, i + 1, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 0, 0, 1, 0, (12 + i) % 16, 7 - i, 1, DW'(16'h3100 + i));
    run_vecs("wrap");

    // Write-then-read of the same slot with pop held high.
    do_reset();
    push = 1'b1; pop = 1'b1; push_data = 16'hABCD;
    #3;
    chk("wtr pop_ready N", pop_ready, 0);
    chk("wtr push_ready N", push_ready, 1);
    @(posedge clk); #1;
    push = 1'b0;
    #3;
    chk("wtr pop_ready N+1", pop_ready, 1);
    chk("wtr rd_addr N+1", mem_rd_addr, 0);
    @(posedge clk); #1;
    pop = 1'b0;
    chk("wtr pop_valid N+2", pop_valid, 1);
    chk("wtr pop_data N+2", pop_data, 16'hABCD);
    chk("wtr empty N+2", empty, 1);

    // Reset with a pop in flight and count=7.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; push_data = DW'(16'h4000 + i);
      @(posedge clk); #1;
    end
    push = 1'b0; pop = 1'b1;
    @(posedge clk); #1;
    pop = 1'b0;
    chk("rstmid pre pop_valid", pop_valid, 1);
    chk("rstmid pre count", count, 7);
    push = 1'b1; push_data = 16'h5555;
    rst = 1'b1;
    #1;
    chk("rstmid pop_valid", pop_valid, 0);
    chk("rstmid count", count, 0);
    chk("rstmid empty", empty, 1);
    chk("rstmid full", full, 0);
    chk("rstmid wr_addr", mem_wr_addr, 0);
    chk("rstmid rd_addr", mem_rd_addr, 0);
    chk("rstmid no grant", push_ready, 0);
    @(posedge clk); #1;
    chk("rstmid held count", count, 0);
    rst = 1'b0;
    #2;
    chk("rstmid post push_ready", push_ready, 1);
    chk("rstmid post wr_addr", mem_wr_addr, 0);
    @(posedge clk); #1;
    push = 1'b0;
    chk("rstmid post count", count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
